// File: rtl/cjmcu1401_line_capture.sv
// CJMCU-1401 receive path: SI/trigger-driven ADC capture into a ping-pong line
// buffer, with completed lines streamed out over ready/valid.
module cjmcu1401_line_capture #(
  parameter int NUMBER_OF_PIXEL  = 128,
  parameter int ADC_WIDTH        = 12,
  parameter int ADC_TIMEOUT_NCLK = 60
) (
  input  logic                 master_clock,
  input  logic                 master_reset,
  input  logic                 cjmcu1401_si,
  input  logic                 sample_capture_trigger,
  output logic                 adc_start,
  input  logic                 adc_done,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic [ADC_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tuser,
  output logic                 m_tlast,
  output logic                 line_dropped,
  output logic                 short_line,
  output logic                 sample_miss,
  input  logic                 err_clear
);

  localparam int PIX_W  = $clog2(NUMBER_OF_PIXEL);
  localparam int ADDR_W = PIX_W + 1;
  localparam int TMO_W  = $clog2(ADC_TIMEOUT_NCLK + 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUMBER_OF_PIXEL - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(ADC_TIMEOUT_NCLK - 1);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CONVERT, STORE} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_idx_q, pix_idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               si_q;
  logic               wbuf_q, wbuf_d;
  logic               line_keep_q, line_keep_d;
  logic [1:0]         full_q, full_d;
  logic               adc_start_q, adc_start_d;
  logic               line_dropped_q, line_dropped_d;
  logic               short_line_q, short_line_d;
  logic               sample_miss_q, sample_miss_d;
  logic               rbuf_q, rbuf_d;
  logic [PIX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [ADC_WIDTH-1:0] rd_data_q;

  logic [ADC_WIDTH-1:0] mem_q [2*NUMBER_OF_PIXEL];
  logic                 mem_we;
  logic [ADC_WIDTH-1:0] mem_wdata;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [ADDR_W-1:0]    rd_addr;

  logic si_rise, commit, release_buf, accept;
  logic drop_evt, short_evt, miss_evt;

  assign si_rise   = cjmcu1401_si & ~si_q;
  assign mem_waddr = {wbuf_q, pix_idx_q};

  // A line whose target buffer is still occupied at SI time is captured
  // without writing RAM and dropped at its last pixel.
  always_comb begin
    state_d     = state_q;
    pix_idx_d   = pix_idx_q;
    tmo_d       = tmo_q;
    wbuf_d      = wbuf_q;
    line_keep_d = line_keep_q;
    adc_start_d = 1'b0;
    commit      = 1'b0;
    drop_evt    = 1'b0;
    short_evt   = 1'b0;
    miss_evt    = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    if (si_rise) begin
      pix_idx_d   = '0;
      state_d     = WAIT_TRIG;
      line_keep_d = ~full_q[wbuf_q];
      short_evt   = (state_q != IDLE);
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_TRIG: begin
          if (sample_capture_trigger) begin
            adc_start_d = 1'b1;
            tmo_d       = TMO_LOAD;
            state_d     = CONVERT;
          end
        end
        CONVERT: begin
          if (sample_capture_trigger) miss_evt = 1'b1;
          if (adc_done) begin
            mem_we    = line_keep_q;
            mem_wdata = adc_data;
            state_d   = STORE;
          end else if (tmo_q == '0) begin
            mem_we    = line_keep_q;
            miss_evt  = 1'b1;
            state_d   = STORE;
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
          end
        end
        STORE: begin
          if (pix_idx_q == LAST_PIX) begin
            pix_idx_d = '0;
            state_d   = IDLE;
            if (line_keep_q) begin
              commit = 1'b1;
              wbuf_d = ~wbuf_q;
            end else begin
              drop_evt = 1'b1;
            end
          end else begin
            pix_idx_d = pix_idx_q + PIX_W'(1);
            state_d   = WAIT_TRIG;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Address is taken from the next-cycle index so the registered RAM output
  // lines up with m_tvalid and simply re-reads the same word while stalled.
  always_comb begin
    accept      = m_tvalid_q & m_tready;
    rd_idx_d    = rd_idx_q;
    rbuf_d      = rbuf_q;
    m_tvalid_d  = m_tvalid_q;
    release_buf = 1'b0;
    if (!m_tvalid_q) begin
      if (full_q[rbuf_q]) begin
        m_tvalid_d = 1'b1;
        rd_idx_d   = '0;
      end
    end else if (accept) begin
      if (rd_idx_q == LAST_PIX) begin
        m_tvalid_d  = 1'b0;
        release_buf = 1'b1;
        rbuf_d      = ~rbuf_q;
      end else begin
        rd_idx_d = rd_idx_q + PIX_W'(1);
      end
    end
    rd_addr = {rbuf_q, rd_idx_d};
  end

  always_comb begin
    full_d = full_q;
    if (commit)      full_d[wbuf_q] = 1'b1;
    if (release_buf) full_d[rbuf_q] = 1'b0;
    line_dropped_d = (line_dropped_q & ~err_clear) | drop_evt;
    short_line_d   = (short_line_q & ~err_clear) | short_evt;
    sample_miss_d  = (sample_miss_q & ~err_clear) | miss_evt;
  end

  always_ff @(posedge master_clock) begin
    if (master_reset) begin
      state_q        <= IDLE;
      pix_idx_q      <= '0;
      tmo_q          <= '0;
      si_q           <= 1'b0;
      wbuf_q         <= 1'b0;
      line_keep_q    <= 1'b0;
      full_q         <= '0;
      adc_start_q    <= 1'b0;
      line_dropped_q <= 1'b0;
      short_line_q   <= 1'b0;
      sample_miss_q  <= 1'b0;
      rbuf_q         <= 1'b0;
      rd_idx_q       <= '0;
      m_tvalid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      pix_idx_q      <= pix_idx_d;
      tmo_q          <= tmo_d;
      si_q           <= cjmcu1401_si;
      wbuf_q         <= wbuf_d;
      line_keep_q    <= line_keep_d;
      full_q         <= full_d;
      adc_start_q    <= adc_start_d;
      line_dropped_q <= line_dropped_d;
      short_line_q   <= short_line_d;
      sample_miss_q  <= sample_miss_d;
      rbuf_q         <= rbuf_d;
      rd_idx_q       <= rd_idx_d;
      m_tvalid_q     <= m_tvalid_d;
      rd_data_q      <= mem_q[rd_addr];
    end
  end

  always_ff @(posedge master_clock) begin
    if (mem_we && !master_reset) mem_q[mem_waddr] <= mem_wdata;
  end

  assign adc_start    = adc_start_q;
  assign m_tdata      = rd_data_q;
  assign m_tvalid     = m_tvalid_q;
  assign m_tuser      = m_tvalid_q & (rd_idx_q == '0);
  assign m_tlast      = m_tvalid_q & (rd_idx_q == LAST_PIX);
  assign line_dropped = line_dropped_q;
  assign short_line   = short_line_q;
  assign sample_miss  = sample_miss_q;

endmodule
